pool_layer_array: RTL and testbench
===================================

# pool_layer_array

Parametrised successor to the single-channel global average pooling stage in the post-convolution path. One block pools NUM_CHANNELS convolution channels in parallel and replaces the per-kernel absolute-value and pooling pair. Per frame it takes INPUT_SIZE beats, applies an optional absolute value and computes either the average or the maximum per channel. It then presents one NUM_CHANNELS-wide result vector to the serializer with a valid/yumi handshake.

## Interface
- WORD_SIZE, 16, bits per fixed-point word (two's complement)
- INT_BITS, 4, integer bits; fraction bits N_SIZE = WORD_SIZE-INT_BITS
- NUM_CHANNELS, 256, parallel channels pooled per frame
- INPUT_SIZE, 241, beats per frame (>= 2)
- ABS_EN, 1, 1 = take absolute value of each input before pooling
- clk_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  synchronous, active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept a beat; a beat transfers when valid_i & ready_o
- data_i  in  [NUM_CHANNELS-1:0][WORD_SIZE-1:0]  one signed sample per channel
- mode_i  in  1  0 = average, 1 = max; sampled on the first beat of a frame
- valid_o  out  1  result vector valid; held until yumi_i
- yumi_i  in  1  consumer takes the result this cycle (only legal while valid_o)
- data_o  out  [NUM_CHANNELS-1:0][WORD_SIZE-1:0]  pooled result per channel, registered

## Operation
- States: ACCUM, SCALE, OUT. Reset enters ACCUM with beat count 0, accumulators cleared and the mode register cleared.
- ACCUM: ready_o = 1. Each transfer increments the beat count.
  - Pre-processing per channel: x' = |x| when ABS_EN, else x.
  - |0x8000| saturates to 0x7FFF.
- On the first beat of a frame (count 0):
  - mode_i is latched for the whole frame.
  - Each accumulator is loaded with x' rather than updated.
- Average mode: acc += x'. The accumulator is signed, WORD_SIZE+$clog2(INPUT_SIZE) bits wide and cannot overflow.
- Max mode: acc = max(acc, x') as a signed compare.
- When the transfer with count = INPUT_SIZE-1 completes, go to SCALE and reset the count to 0.
- SCALE, one cycle, ready_o = 0:
  - Average: result = (acc * RECIP) >>> N_SIZE, where RECIP = round(2^N_SIZE / INPUT_SIZE) is an elaboration-time constant. The shift is arithmetic (truncation toward -inf).
  - The result saturates to [0x8000, 0x7FFF] (WORD_SIZE generalised). Max mode passes acc through unchanged.
  - data_o is registered, valid_o is set and the block enters OUT.
- OUT: ready_o = 0 and valid_o = 1; data_o is stable.
  - On yumi_i, valid_o clears next cycle and the block returns to ACCUM.
- Ignored inputs:
  - valid_i while ready_o = 0 (no transfer).
  - yumi_i while valid_o = 0.
  - mode_i changes mid-frame.

## Timing
- Reset values: ready_o = 0 during the reset cycle, then 1; valid_o = 0; data_o = 0.
- Latency: if the last beat of a frame transfers at edge t, valid_o rises at edge t+2 (t+1 enters SCALE).
- Throughput: INPUT_SIZE + 2 + (cycles waiting for yumi_i) per frame.
- Minimum period, with yumi_i tied high: INPUT_SIZE+3 cycles.
- ready_o rises the cycle after the yumi_i edge. It is never high in the same cycle as valid_o.
- Gaps in valid_i mid-frame are allowed; count and accumulators hold across them.
- Reset mid-frame or while valid_o is high:
  - The partial frame is discarded and valid_o drops at that edge.
  - The next accepted beat is the first beat of a new frame.
- Channels are fully independent. All channels share one count, one state and one mode.

## Test plan
Common setup: WORD_SIZE=16, INT_BITS=4, INPUT_SIZE=4, NUM_CHANNELS=2, ABS_EN=1, yumi_i=1 unless stated. Hex values are Q4.12.
- Average: ch0 gets 0x1000, 0x2000, 0x3000, 0x4000; ch1 gets 0xF000 ×4, mode_i=0 → data_o ch0 = 0x2800, ch1 = 0x1000; valid_o rises 2 cycles after the last beat.
- Max: ch0 gets 0x0100, 0x7000, 0xF000, 0x0200; ch1 gets 0x8000 ×4, mode_i=1 → ch0 = 0x7000, ch1 = 0x7FFF.
- Back-pressure:
  - Hold yumi_i = 0 for 5 cycles with valid_i = 1 throughout → valid_o and data_o stay stable and ready_o = 0 for the whole wait.
  - Then raise yumi_i → ready_o = 1 next cycle and no input beat is lost or double-counted.
- ABS_EN=0 build: ch1 gets 0xF000 ×4, average → ch1 = 0xF000. Inserting 3 idle cycles between beats 2 and 3 gives the same result.
- Reset mid-frame:
  - Transfer 2 beats of 0x7000, assert reset_i for 1 cycle, then send 4 beats of 0x1000 → result = 0x1000 per channel.
  - Toggling mode_i after the first beat has no effect on the result.
- Back-to-back frames: alternate mode_i=0 and 1 across 3 frames → each result matches its frame's latched mode, and the frame period is 7 cycles.

Source files
------------

// File: rtl/pool_layer_array.sv
// pool_layer_array: pools NUM_CHANNELS signed channels over INPUT_SIZE-beat frames
// (average or max, optional abs) and presents the result vector on a valid/yumi handshake.
module pool_layer_array #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned INT_BITS     = 4,
  parameter int unsigned NUM_CHANNELS = 256,
  parameter int unsigned INPUT_SIZE   = 241,
  parameter bit          ABS_EN       = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  input  logic [NUM_CHANNELS-1:0][WORD_SIZE-1:0] data_i,
  input  logic                                   mode_i,
  output logic                                   valid_o,
  input  logic                                   yumi_i,
  output logic [NUM_CHANNELS-1:0][WORD_SIZE-1:0] data_o
);

  localparam int unsigned N_SIZE  = WORD_SIZE - INT_BITS;
  localparam int unsigned CNT_W   = $clog2(INPUT_SIZE);
  localparam int unsigned ACC_W   = WORD_SIZE + CNT_W;
  localparam int unsigned RECIP_W = N_SIZE + 2;
  localparam int unsigned PROD_W  = ACC_W + RECIP_W;

  // Rounded reciprocal of the frame length, in the word's fraction format.
  localparam logic [63:0] RECIP_VAL =
    ((64'(1) << N_SIZE) + 64'(INPUT_SIZE / 2)) / 64'(INPUT_SIZE);
  localparam logic signed [RECIP_W-1:0] RECIP    = RECIP_W'(RECIP_VAL);
  localparam logic [CNT_W-1:0]          LAST_CNT = CNT_W'(INPUT_SIZE - 1);
  localparam logic [WORD_SIZE-1:0]      W_MAX    = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic [WORD_SIZE-1:0]      W_MIN    = {1'b1, {(WORD_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, SCALE, OUT} state_e;

  state_e                                 state;
  logic [CNT_W-1:0]                       count;
  logic                                   mode_q;
  logic                                   x_vld;
  logic                                   x_first;
  logic                                   x_last;
  logic                                   accept;
  logic [NUM_CHANNELS-1:0][WORD_SIZE-1:0] res_c;

  function automatic logic [WORD_SIZE-1:0] pre_proc(input logic [WORD_SIZE-1:0] x);
    logic [WORD_SIZE-1:0] y;
    y = x;
    if (ABS_EN && x[WORD_SIZE-1]) begin
      y = (x == W_MIN) ? W_MAX : WORD_SIZE'(-x);
    end
    return y;
  endfunction

  // Beats land in a per-channel input register first; the final beat is still in
  // flight for one cycle, so acceptance stays closed until it reaches the accumulator.
  assign ready_o = (state == ACCUM) && !(x_vld && x_last) && !reset_i;
  assign accept  = valid_i && ready_o;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic signed [WORD_SIZE-1:0] x_q;
    logic signed [ACC_W-1:0]     x_ext;
    logic signed [ACC_W-1:0]     acc;
    logic signed [PROD_W-1:0]    prod;
    logic signed [PROD_W-1:0]    shifted;
    logic [WORD_SIZE-1:0]        avg;

    assign x_ext = ACC_W'(x_q);

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        x_q <= '0;
        acc <= '0;
      end else begin
        if (accept) begin
          x_q <= pre_proc(data_i[c]);
        end
        if (x_vld) begin
          if (x_first) begin
            acc <= x_ext;
          end else if (mode_q) begin
            if (x_ext > acc) begin
              acc <= x_ext;
            end
          end else begin
            acc <= acc + x_ext;
          end
        end
      end
    end

    // Average = acc * RECIP, arithmetic shift back to the word's fraction, then saturate.
    assign prod    = PROD_W'(acc) * PROD_W'(RECIP);
    assign shifted = prod >>> N_SIZE;

    always_comb begin
      avg = shifted[WORD_SIZE-1:0];
      if ((shifted[PROD_W-1:WORD_SIZE-1] != '0) && (shifted[PROD_W-1:WORD_SIZE-1] != '1)) begin
        avg = shifted[PROD_W-1] ? W_MIN : W_MAX;
      end
    end

    assign res_c[c] = mode_q ? acc[WORD_SIZE-1:0] : avg;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= ACCUM;
      count   <= '0;
      mode_q  <= 1'b0;
      x_vld   <= 1'b0;
      x_first <= 1'b0;
      x_last  <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      x_vld   <= accept;
      x_first <= accept && (count == '0);
      x_last  <= accept && (count == LAST_CNT);
      case (state)
        ACCUM: begin
          if (accept) begin
            count <= (count == LAST_CNT) ? '0 : count + CNT_W'(1);
            if (count == '0) begin
              mode_q <= mode_i;
            end
          end
          if (x_vld && x_last) begin
            state <= SCALE;
          end
        end
        SCALE: begin
          data_o  <= res_c;
          valid_o <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (yumi_i) begin
            valid_o <= 1'b0;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_layer_array.sv
// Bench for pool_layer_array: directed table, multi-cycle corner sequences and random frames
// against an arithmetic reference model; a second instance is built without the abs stage.
module tb_pool_layer_array;
  localparam int unsigned WS    = 16;
  localparam int unsigned NCH   = 2;
  localparam int unsigned NB    = 4;
  localparam int unsigned NFRAC = 12;

  typedef logic [WS-1:0]          word_t;
  typedef logic [NCH-1:0][WS-1:0] vec_t;
  typedef struct {
    word_t c0[NB];
    word_t c1[NB];
    logic  mode;
    word_t e0;
    word_t e1;
    word_t na1;
  } tv_t;

  logic  clk = 1'b0;
  logic  reset_i, valid_i, mode_i, yumi_i;
  vec_t  data_i;
  logic  ready, valid, ready_na, valid_na;
  vec_t  data_o, data_na;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    first_xfer, last_xfer;
  vec_t  res_q[$];
  vec_t  resna_q[$];
  int    rise_q[$];
  logic  prev_v = 1'b0;
  bit    overlap = 1'b0;
  bit    twin_diff = 1'b0;

  tv_t   tv[5];
  word_t a0[NB], a1[NB];
  word_t f0[3][NB], f1[3][NB];
  int    fx[3];
  logic  fm[3];
  vec_t  r, rna;
  int    n;

  pool_layer_array #(.WORD_SIZE(WS), .INT_BITS(4), .NUM_CHANNELS(NCH), .INPUT_SIZE(NB),
                     .ABS_EN(1'b1)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready), .data_i(data_i),
    .mode_i(mode_i), .valid_o(valid), .yumi_i(yumi_i), .data_o(data_o));

  pool_layer_array #(.WORD_SIZE(WS), .INT_BITS(4), .NUM_CHANNELS(NCH), .INPUT_SIZE(NB),
                     .ABS_EN(1'b0)) dut_na (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_na), .data_i(data_i),
    .mode_i(mode_i), .valid_o(valid_na), .yumi_i(yumi_i), .data_o(data_na));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake collector: results are taken in the cycle where valid and yumi coincide.
  always @(negedge clk) begin
    if (valid === 1'b1 && prev_v !== 1'b1) rise_q.push_back(cyc);
    prev_v = valid;
    if (ready === 1'b1 && valid === 1'b1) overlap = 1'b1;
    if (ready_na !== ready || valid_na !== valid) twin_diff = 1'b1;
    if (valid === 1'b1 && yumi_i === 1'b1) begin
      res_q.push_back(data_o);
      resna_q.push_back(data_na);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t model(input word_t s[NB], input bit mode, input bit abs_en);
    longint acc, v, recip;
    recip = longint'($rtoi(real'(longint'(1) << NFRAC) / real'(NB) + 0.5));
    acc = 0;
    for (int i = 0; i < NB; i++) begin
      v = longint'($signed(s[i]));
      if (abs_en && v < 0) v = (v == -32768) ? 32767 : -v;
      if (i == 0) acc = v;
      else if (mode) acc = (v > acc) ? v : acc;
      else acc = acc + v;
    end
    if (!mode) begin
      acc = (acc * recip) >>> NFRAC;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
    end
    return word_t'(acc);
  endfunction

  function automatic word_t rnd_word();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      default: return word_t'($urandom);
    endcase
  endfunction

  // Holds one beat until it transfers; returns at posedge+1 of the transfer edge.
  task automatic send_beat(input vec_t d, input logic m);
    logic rd;
    valid_i = 1'b1;
    data_i  = d;
    mode_i  = m;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rd = ready;
      step();
      if (rd === 1'b1) begin
        last_xfer = cyc;
        return;
      end
    end
    check("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input word_t c0[NB], input word_t c1[NB], input logic m,
                            input int gap_at, input int gap_len, input bit toggle);
    for (int i = 0; i < NB; i++) begin
      send_beat({c1[i], c0[i]}, (toggle && i > 0) ? ~m : m);
      if (i == 0) first_xfer = last_xfer;
      if (i == gap_at) begin
        valid_i = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          data_i = {word_t'($urandom), word_t'($urandom)};
          mode_i = ~mode_i;
          step();
        end
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic get_result(output vec_t rr, output vec_t rn);
    int k = 0;
    while (res_q.size() == 0 && k < 40) begin
      step();
      k++;
    end
    if (res_q.size() == 0) begin
      check("result_timeout", 32'd0, 32'd1);
      rr = '0;
      rn = '0;
    end else begin
      rr = res_q.pop_front();
      rn = resna_q.pop_front();
    end
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; yumi_i = 1'b1; mode_i = 1'b0; data_i = '0;

    tv[0].c0 = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    tv[0].c1 = '{16'hF000, 16'hF000, 16'hF000, 16'hF000};
    tv[0].mode = 1'b0; tv[0].e0 = 16'h2800; tv[0].e1 = 16'h1000; tv[0].na1 = 16'hF000;
    tv[1].c0 = '{16'h0100, 16'h7000, 16'hF000, 16'h0200};
    tv[1].c1 = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tv[1].mode = 1'b1; tv[1].e0 = 16'h7000; tv[1].e1 = 16'h7FFF; tv[1].na1 = 16'h8000;
    tv[2].c0 = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tv[2].c1 = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tv[2].mode = 1'b0; tv[2].e0 = 16'h7FFF; tv[2].e1 = 16'h7FFF; tv[2].na1 = 16'h8000;
    tv[3].c0 = '{16'h0001, 16'h0001, 16'h0001, 16'h0000};
    tv[3].c1 = '{16'h0004, 16'h0000, 16'h0000, 16'h0000};
    tv[3].mode = 1'b0; tv[3].e0 = 16'h0000; tv[3].e1 = 16'h0001; tv[3].na1 = 16'h0001;
    tv[4].c0 = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0001};
    tv[4].c1 = '{16'hFFFE, 16'h0001, 16'h0001, 16'h0001};
    tv[4].mode = 1'b1; tv[4].e0 = 16'h0001; tv[4].e1 = 16'h0002; tv[4].na1 = 16'h0001;

    // Reset values
    step();
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data_o, 0);
    step();
    reset_i = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ready, 1);
    step();

    // Directed table, with latency from last beat to valid_o
    for (int i = 0; i < 5; i++) begin
      rise_q.delete();
      send_frame(tv[i].c0, tv[i].c1, tv[i].mode, -1, 0, 1'b0);
      get_result(r, rna);
      check($sformatf("tv%0d_ch0", i), r[0], tv[i].e0);
      check($sformatf("tv%0d_ch1", i), r[1], tv[i].e1);
      check($sformatf("tv%0d_noabs_ch1", i), rna[1], tv[i].na1);
      check($sformatf("tv%0d_latency", i), (rise_q.size() > 0) ? rise_q[0] : -1, last_xfer + 2);
    end

    // Idle gap mid-frame on both builds
    a0 = '{16'h0800, 16'h0800, 16'h0800, 16'h0800};
    a1 = '{16'hF000, 16'hF000, 16'hF000, 16'hF000};
    send_frame(a0, a1, 1'b0, 1, 3, 1'b0);
    get_result(r, rna);
    check("gap_ch0", r[0], 16'h0800);
    check("gap_ch1", r[1], 16'h1000);
    check("gap_noabs_ch1", rna[1], 16'hF000);

    // Back-pressure: yumi low for 5 cycles while the next frame's first beat is offered
    yumi_i = 1'b0;
    send_frame(tv[0].c0, tv[0].c1, 1'b0, -1, 0, 1'b0);
    a0 = '{16'h0100, 16'h0500, 16'h0900, 16'h0D00};
    a1 = '{16'h0300, 16'h8000, 16'hC000, 16'h0040};
    valid_i = 1'b1; data_i = {a1[0], a0[0]}; mode_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < 20);
    check("bp_valid_rise", valid, 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_valid%0d", k), valid, 1);
      check($sformatf("bp_hold_data%0d", k), data_o, {16'h1000, 16'h2800});
      check($sformatf("bp_hold_ready%0d", k), ready, 0);
      @(negedge clk);
    end
    step();
    yumi_i = 1'b1;
    @(negedge clk);
    check("bp_yumi_cycle_ready", ready, 0);
    step();
    @(negedge clk);
    check("bp_ready_after_yumi", ready, 1);
    check("bp_valid_after_yumi", valid, 0);
    step();
    for (int i = 1; i < NB; i++) send_beat({a1[i], a0[i]}, 1'b0);
    valid_i = 1'b0;
    get_result(r, rna);
    check("bp_held_ch0", r[0], 16'h2800);
    check("bp_held_ch1", r[1], 16'h1000);
    get_result(r, rna);
    check("bp_next_ch0", r[0], model(a0, 1'b0, 1'b1));
    check("bp_next_ch1", r[1], model(a1, 1'b0, 1'b1));
    check("bp_next_noabs_ch1", rna[1], model(a1, 1'b0, 1'b0));

    // Reset mid-frame discards the partial frame
    send_beat({16'h7000, 16'h7000}, 1'b0);
    send_beat({16'h7000, 16'h7000}, 1'b0);
    valid_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk);
    check("midrst_ready", ready, 0);
    step();
    reset_i = 1'b0;
    a0 = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    send_frame(a0, a0, 1'b0, -1, 0, 1'b0);
    get_result(r, rna);
    check("midrst_ch0", r[0], 16'h1000);
    check("midrst_ch1", r[1], 16'h1000);

    // mode_i toggled after the first beat is ignored
    a0 = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    a1 = '{16'h0100, 16'h0900, 16'h0200, 16'h0300};
    send_frame(a0, a1, 1'b0, -1, 0, 1'b1);
    get_result(r, rna);
    check("toggle_ch0", r[0], 16'h2800);
    check("toggle_ch1", r[1], model(a1, 1'b0, 1'b1));

    // Reset while valid_o is high drops the result
    yumi_i = 1'b0;
    send_frame(tv[1].c0, tv[1].c1, 1'b1, -1, 0, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (valid !== 1'b1 && n < 20);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_out_valid", valid, 0);
    check("rst_out_data", data_o, 0);
    check("rst_out_no_result", res_q.size(), 0);
    step();
    yumi_i = 1'b1;

    // Back-to-back frames with alternating mode
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NB; i++) begin
        f0[k][i] = rnd_word();
        f1[k][i] = rnd_word();
      end
      fm[k] = k[0];
      send_frame(f0[k], f1[k], fm[k], -1, 0, 1'b0);
      fx[k] = first_xfer;
    end
    for (int k = 0; k < 3; k++) begin
      get_result(r, rna);
      check($sformatf("b2b%0d_ch0", k), r[0], model(f0[k], fm[k], 1'b1));
      check($sformatf("b2b%0d_ch1", k), r[1], model(f1[k], fm[k], 1'b1));
      check($sformatf("b2b%0d_noabs_ch0", k), rna[0], model(f0[k], fm[k], 1'b0));
    end
    check("b2b_period1", fx[1] - fx[0], 7);
    check("b2b_period2", fx[2] - fx[1], 7);

    // Random frames with random gaps and mid-frame mode noise
    for (int k = 0; k < 30; k++) begin
      logic m;
      for (int i = 0; i < NB; i++) begin
        a0[i] = rnd_word();
        a1[i] = rnd_word();
      end
      m = 1'($urandom_range(0, 1));
      send_frame(a0, a1, m, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      get_result(r, rna);
      check($sformatf("rnd%0d_ch0", k), r[0], model(a0, m, 1'b1));
      check($sformatf("rnd%0d_ch1", k), r[1], model(a1, m, 1'b1));
      check($sformatf("rnd%0d_noabs_ch0", k), rna[0], model(a0, m, 1'b0));
      check($sformatf("rnd%0d_noabs_ch1", k), rna[1], model(a1, m, 1'b0));
    end

    check("ready_valid_overlap", overlap, 0);
    check("builds_handshake_agree", twin_diff, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
